clock_hms_display: RTL and testbench



---
 rtl/clock_hms_display.sv | 225 ++++++++++++++++++++++
 tb/tb_clock_hms_display.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/clock_hms_display.sv
// ---------------------------------------------------------------------------
// clock_hms_display
//   24-hour real-time clock with a multiplexed seven-segment display driver.
//   A prescaler makes a once-per-second enable that advances cascaded BCD
//   counters (ss -> mm -> hh). Time can be paused, loaded in parallel (with
//   range validation) and shown in 12- or 24-hour format.
//
// Parameters
//   CLK_HZ     : clk frequency; one second = CLK_HZ cycles
//   SCAN_HZ    : full display refresh rate
//   NUM_DIGITS : 6 (HH MM SS) or 4 (HH MM)
//
// Ports
//   clk, rst                 : clock, synchronous active-high reset
//   run                      : 1 = time advances, 0 = prescaler holds
//   mode_12h                 : display-only 12-hour format
//   load                     : one-cycle strobe for load_hh/load_mm/load_ss
//   load_hh/load_mm/load_ss  : packed BCD load values
//   hh, mm, ss               : current time, packed BCD, 24-hour
//   pm                       : hh >= 12
//   tick                     : one-cycle pulse with every time update
//   rollover                 : one-cycle pulse on 23:59:59 -> 00:00:00
//   load_err                 : one-cycle pulse after a rejected load
//   seg                      : active-low segments {g,f,e,d,c,b,a}
//   an                       : active-low one-hot digit enable
// ---------------------------------------------------------------------------
module clock_hms_display #(
    parameter int CLK_HZ     = 50000000,
    parameter int SCAN_HZ    = 1000,
    parameter int NUM_DIGITS = 6
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  run,
    input  logic                  mode_12h,
    input  logic                  load,
    input  logic [7:0]            load_hh,
    input  logic [7:0]            load_mm,
    input  logic [7:0]            load_ss,
    output logic [7:0]            hh,
    output logic [7:0]            mm,
    output logic [7:0]            ss,
    output logic                  pm,
    output logic                  tick,
    output logic                  rollover,
    output logic                  load_err,
    output logic [6:0]            seg,
    output logic [NUM_DIGITS-1:0] an
);

    localparam int SCAN_DIV = CLK_HZ / (SCAN_HZ * NUM_DIGITS);
    localparam int CNT_W    = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
    localparam int SC_W     = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int IDX_W    = $clog2(NUM_DIGITS);

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CLK_HZ - 1);
    localparam logic [SC_W-1:0]  SC_MAX  = SC_W'(SCAN_DIV - 1);
    localparam logic [IDX_W-1:0] IDX_MAX = IDX_W'(NUM_DIGITS - 1);
    // A 4-digit display has no seconds, so its digit 0 is minutes-units.
    localparam logic [2:0]       POS_OFS = (NUM_DIGITS == 4) ? 3'd2 : 3'd0;

    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [SC_W-1:0]       sc_q, sc_d;
    logic [IDX_W-1:0]      idx_q, idx_d;
    logic [7:0]            hh_q, hh_d, mm_q, mm_d, ss_q, ss_d;
    logic                  tick_q, tick_d;
    logic                  rollover_q, rollover_d;
    logic                  load_err_q, load_err_d;
    logic [6:0]            seg_q, seg_d;
    logic [NUM_DIGITS-1:0] an_q, an_d;

    logic                  at_tc;
    logic                  load_ok;
    logic [7:0]            hh_show;
    logic [2:0]            pos;
    logic [3:0]            digit;

    function automatic logic [7:0] bcd_inc(input logic [7:0] v);
        if (v[3:0] == 4'd9) return {v[7:4] + 4'd1, 4'd0};
        else                return {v[7:4], v[3:0] + 4'd1};
    endfunction

    // 00 -> 12, 13..23 -> 1..11, everything else unchanged.
    function automatic logic [7:0] to_12h(input logic [7:0] h);
        logic [4:0] bin;
        bin = 5'(h[7:4]) * 5'd10 + 5'(h[3:0]);
        if (bin == 5'd0)        bin = 5'd12;
        else if (bin >= 5'd13)  bin = bin - 5'd12;
        if (bin >= 5'd10) return {4'd1, 4'(bin - 5'd10)};
        else              return {4'd0, bin[3:0]};
    endfunction

    function automatic logic [6:0] glyph(input logic [3:0] d);
        case (d)
            4'd0:    return 7'b1000000;
            4'd1:    return 7'b1111001;
            4'd2:    return 7'b0100100;
            4'd3:    return 7'b0110000;
            4'd4:    return 7'b0011001;
            4'd5:    return 7'b0010010;
            4'd6:    return 7'b0000010;
            4'd7:    return 7'b1111000;
            4'd8:    return 7'b0000000;
            4'd9:    return 7'b0010000;
            default: return SEG_BLANK;
        endcase
    endfunction

    always_comb begin
        cnt_d      = cnt_q;
        hh_d       = hh_q;
        mm_d       = mm_q;
        ss_d       = ss_q;
        tick_d     = 1'b0;
        rollover_d = 1'b0;
        load_err_d = 1'b0;

        load_ok = (load_hh[3:0] <= 4'd9) && (load_mm[3:0] <= 4'd9) &&
                  (load_ss[3:0] <= 4'd9) && (load_hh <= 8'h23) &&
                  (load_mm <= 8'h59) && (load_ss <= 8'h59);

        at_tc = run && (cnt_q == CNT_MAX);

        if (run) cnt_d = at_tc ? '0 : cnt_q + CNT_W'(1);

        if (at_tc) begin
            tick_d = 1'b1;
            if (ss_q == 8'h59) begin
                ss_d = 8'h00;
                if (mm_q == 8'h59) begin
                    mm_d = 8'h00;
                    if (hh_q == 8'h23) begin
                        hh_d       = 8'h00;
                        rollover_d = 1'b1;
                    end else begin
                        hh_d = bcd_inc(hh_q);
                    end
                end else begin
                    mm_d = bcd_inc(mm_q);
                end
            end else begin
                ss_d = bcd_inc(ss_q);
            end
        end

        // A valid load overrides a coincident second tick entirely.
        if (load) begin
            if (load_ok) begin
                hh_d       = load_hh;
                mm_d       = load_mm;
                ss_d       = load_ss;
                cnt_d      = '0;
                tick_d     = 1'b0;
                rollover_d = 1'b0;
            end else begin
                load_err_d = 1'b1;
            end
        end
    end

    // Display is computed from the next index and next time so that seg/an
    // and the exported time change on the same edge.
    always_comb begin
        sc_d  = (sc_q == SC_MAX) ? '0 : sc_q + SC_W'(1);
        idx_d = idx_q;
        if (sc_q == SC_MAX) idx_d = (idx_q == IDX_MAX) ? '0 : idx_q + IDX_W'(1);

        hh_show = mode_12h ? to_12h(hh_d) : hh_d;
        pos     = 3'(idx_d) + POS_OFS;

        case (pos)
            3'd0:    digit = ss_d[3:0];
            3'd1:    digit = ss_d[7:4];
            3'd2:    digit = mm_d[3:0];
            3'd3:    digit = mm_d[7:4];
            3'd4:    digit = hh_show[3:0];
            3'd5:    digit = (mode_12h && hh_show[7:4] == 4'd0) ? 4'hF : hh_show[7:4];
            default: digit = 4'hF;
        endcase

        seg_d = glyph(digit);
        an_d  = ~(NUM_DIGITS'(1) << idx_d);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q      <= '0;
            sc_q       <= '0;
            idx_q      <= '0;
            hh_q       <= 8'h00;
            mm_q       <= 8'h00;
            ss_q       <= 8'h00;
            tick_q     <= 1'b0;
            rollover_q <= 1'b0;
            load_err_q <= 1'b0;
            seg_q      <= 7'b1000000;
            an_q       <= ~NUM_DIGITS'(1);
        end else begin
            cnt_q      <= cnt_d;
            sc_q       <= sc_d;
            idx_q      <= idx_d;
            hh_q       <= hh_d;
            mm_q       <= mm_d;
            ss_q       <= ss_d;
            tick_q     <= tick_d;
            rollover_q <= rollover_d;
            load_err_q <= load_err_d;
            seg_q      <= seg_d;
            an_q       <= an_d;
        end
    end

    assign hh       = hh_q;
    assign mm       = mm_q;
    assign ss       = ss_q;
    assign pm       = (hh_q >= 8'h12);
    assign tick     = tick_q;
    assign rollover = rollover_q;
    assign load_err = load_err_q;
    assign seg      = seg_q;
    assign an       = an_q;

endmodule

// File: tb/tb_clock_hms_display.sv
module tb_clock_hms_display;

    localparam logic [6:0] G0 = 7'b1000000, G1 = 7'b1111001, G2 = 7'b0100100,
                           G3 = 7'b0110000, G4 = 7'b0011001, G5 = 7'b0010010,
                           G6 = 7'b0000010, G8 = 7'b0000000,
                           G9 = 7'b0010000, GB = 7'b1111111;

    logic       clk = 1'b0;
    logic       rst, run, mode_12h, load;
    logic [7:0] load_hh, load_mm, load_ss;
    logic [7:0] hh, mm, ss;
    logic       pm, tick, rollover, load_err;
    logic [6:0] seg;
    logic [5:0] an;

    always #5 clk = ~clk;

    clock_hms_display #(.CLK_HZ(120), .SCAN_HZ(10), .NUM_DIGITS(6)) dut (
        .clk(clk), .rst(rst), .run(run), .mode_12h(mode_12h), .load(load),
        .load_hh(load_hh), .load_mm(load_mm), .load_ss(load_ss),
        .hh(hh), .mm(mm), .ss(ss), .pm(pm), .tick(tick), .rollover(rollover),
        .load_err(load_err), .seg(seg), .an(an)
    );

    typedef struct {
        logic [7:0] lhh, lmm, lss;
        logic       m12;
        logic       err;
        logic [7:0] ehh, emm, ess;
        logic       epm;
        logic [6:0] seg_ht, seg_hu;
    } vec_t;

    vec_t vecs[12];
    vec_t exp_q[$];

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic cycles(input int n);
        repeat (n) cyc();
    endtask

    task automatic wait_an(input logic [5:0] want, input string name);
        int k;
        k = 0;
        while (an !== want && k < 30) begin
            cyc();
            k++;
        end
        if (an !== want) chk({name, " scan timeout"}, {26'd0, an}, {26'd0, want});
    endtask

    task automatic do_load(input logic [7:0] h, input logic [7:0] m, input logic [7:0] s);
        load = 1'b1; load_hh = h; load_mm = m; load_ss = s;
        cyc();
        load = 1'b0;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int nt, nr, k;
        vec_t e;
        logic [5:0] an_exp[6];
        logic [6:0] seg_exp[6];

        vecs[0]  = '{8'h10, 8'h20, 8'h30, 1'b0, 1'b0, 8'h10, 8'h20, 8'h30, 1'b0, G1, G0};
        vecs[1]  = '{8'h24, 8'h00, 8'h00, 1'b0, 1'b1, 8'h10, 8'h20, 8'h30, 1'b0, G1, G0};
        vecs[2]  = '{8'h10, 8'h5A, 8'h00, 1'b0, 1'b1, 8'h10, 8'h20, 8'h30, 1'b0, G1, G0};
        vecs[3]  = '{8'h10, 8'h20, 8'h60, 1'b0, 1'b1, 8'h10, 8'h20, 8'h30, 1'b0, G1, G0};
        vecs[4]  = '{8'h13, 8'h05, 8'h09, 1'b1, 1'b0, 8'h13, 8'h05, 8'h09, 1'b1, GB, G1};
        vecs[5]  = '{8'h00, 8'h30, 8'h00, 1'b1, 1'b0, 8'h00, 8'h30, 8'h00, 1'b0, G1, G2};
        vecs[6]  = '{8'h09, 8'h00, 8'h00, 1'b1, 1'b0, 8'h09, 8'h00, 8'h00, 1'b0, GB, G9};
        vecs[7]  = '{8'h12, 8'h00, 8'h00, 1'b1, 1'b0, 8'h12, 8'h00, 8'h00, 1'b1, G1, G2};
        vecs[8]  = '{8'h09, 8'h00, 8'h00, 1'b0, 1'b0, 8'h09, 8'h00, 8'h00, 1'b0, G0, G9};
        vecs[9]  = '{8'h23, 8'h00, 8'h00, 1'b1, 1'b0, 8'h23, 8'h00, 8'h00, 1'b1, G1, G1};
        vecs[10] = '{8'h1A, 8'h00, 8'h00, 1'b0, 1'b1, 8'h23, 8'h00, 8'h00, 1'b1, G2, G3};
        vecs[11] = '{8'h20, 8'h00, 8'h00, 1'b1, 1'b0, 8'h20, 8'h00, 8'h00, 1'b1, GB, G8};

        an_exp  = '{6'b111110, 6'b111101, 6'b111011, 6'b110111, 6'b101111, 6'b011111};
        seg_exp = '{G6, G5, G4, G3, G2, G1};

        rst = 1'b1; run = 1'b0; mode_12h = 1'b0; load = 1'b0;
        load_hh = 8'h00; load_mm = 8'h00; load_ss = 8'h00;
        cycles(3);

        // reset state
        chk("rst time", {hh, mm, ss}, 24'h000000);
        chk("rst pm", pm, 1'b0);
        chk("rst pulses", {tick, rollover, load_err}, 3'b000);
        chk("rst an", an, 6'b111110);
        chk("rst seg", seg, 7'b1000000);

        // counting, pause and resume
        rst = 1'b0; run = 1'b1;
        nt = 0;
        for (int i = 0; i < 119; i++) begin
            cyc();
            if (tick) nt++;
        end
        chk("count early tick", nt, 0);
        chk("count ss before tc", ss, 8'h00);
        cyc();
        chk("count tick", tick, 1'b1);
        chk("count ss 1", ss, 8'h01);
        run = 1'b0;
        cyc();
        chk("tick one cycle", tick, 1'b0);
        cycles(499);
        chk("pause ss held", ss, 8'h01);
        run = 1'b1;
        cycles(60);
        chk("resume 60 ss", ss, 8'h01);
        cycles(59);
        chk("resume 119 ss", ss, 8'h01);
        cyc();
        chk("resume 120 ss", ss, 8'h02);
        chk("resume tick", tick, 1'b1);

        // rollover
        do_load(8'h23, 8'h59, 8'h58);
        chk("roll load time", {hh, mm, ss}, 24'h235958);
        chk("roll load no tick", tick, 1'b0);
        chk("roll pm before", pm, 1'b1);
        nt = 0; nr = 0;
        for (int i = 1; i <= 240; i++) begin
            cyc();
            if (tick) nt++;
            if (rollover) nr++;
            if (i == 120) begin
                chk("roll first time", {hh, mm, ss}, 24'h235959);
                chk("roll first no rollover", rollover, 1'b0);
            end
            if (i == 240) begin
                chk("roll wrap time", {hh, mm, ss}, 24'h000000);
                chk("roll wrap rollover", rollover, 1'b1);
                chk("roll pm after", pm, 1'b0);
            end
        end
        chk("roll tick count", nt, 2);
        chk("roll rollover count", nr, 1);

        // load coincident with terminal count
        cycles(119);
        do_load(8'h12, 8'h00, 8'h00);
        chk("tc load time", {hh, mm, ss}, 24'h120000);
        chk("tc load no tick", tick, 1'b0);
        nt = 0;
        for (int i = 0; i < 119; i++) begin
            cyc();
            if (tick) nt++;
        end
        chk("tc load early tick", nt, 0);
        cyc();
        chk("tc load next tick", tick, 1'b1);
        chk("tc load next ss", ss, 8'h01);

        // table: loads, validation and 12h display
        run = 1'b0;
        cyc();
        for (int i = 0; i < 12; i++) begin
            mode_12h = vecs[i].m12;
            exp_q.push_back(vecs[i]);
            do_load(vecs[i].lhh, vecs[i].lmm, vecs[i].lss);
            e = exp_q.pop_front();
            chk($sformatf("vec%0d load_err", i), load_err, e.err);
            chk($sformatf("vec%0d time", i), {hh, mm, ss}, {e.ehh, e.emm, e.ess});
            chk($sformatf("vec%0d pm", i), pm, e.epm);
            cyc();
            chk($sformatf("vec%0d load_err pulse", i), load_err, 1'b0);
            wait_an(6'b011111, $sformatf("vec%0d ht", i));
            chk($sformatf("vec%0d seg hh.t", i), seg, e.seg_ht);
            wait_an(6'b101111, $sformatf("vec%0d hu", i));
            chk($sformatf("vec%0d seg hh.u", i), seg, e.seg_hu);
        end

        // scan order at 12:34:56
        mode_12h = 1'b0;
        do_load(8'h12, 8'h34, 8'h56);
        wait_an(6'b011111, "scan sync");
        k = 0;
        while (an === 6'b011111 && k < 5) begin
            cyc();
            k++;
        end
        for (int i = 0; i < 13; i++) begin
            chk($sformatf("scan an %0d", i), an, an_exp[(i / 2) % 6]);
            chk($sformatf("scan seg %0d", i), seg, seg_exp[(i / 2) % 6]);
            cyc();
        end

        // reset mid-second and mid-scan, with an invalid load in the same cycle
        run = 1'b1;
        do_load(8'h05, 8'h06, 8'h07);
        k = 0;
        while (!(k >= 70 && an === 6'b110111) && k < 100) begin
            cyc();
            k++;
        end
        chk("mid reset reached index 3", an, 6'b110111);
        chk("mid reset time held", {hh, mm, ss}, 24'h050607);
        rst = 1'b1; load = 1'b1; load_hh = 8'h24; load_mm = 8'h00; load_ss = 8'h00;
        cyc();
        rst = 1'b0; load = 1'b0;
        chk("mid reset an", an, 6'b111110);
        chk("mid reset seg", seg, 7'b1000000);
        chk("mid reset time", {hh, mm, ss}, 24'h000000);
        chk("mid reset pulses", {tick, rollover, load_err}, 3'b000);
        nt = 0;
        for (int i = 0; i < 119; i++) begin
            cyc();
            if (tick) nt++;
        end
        chk("post reset early tick", nt, 0);
        cyc();
        chk("post reset tick", tick, 1'b1);
        chk("post reset ss", ss, 8'h01);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
